// File: rtl/prog_loader_if.sv
// Stream-input and program-memory-write bundle for the HC4 program loader.
// master = host side (drives the byte stream), slave = loader.
interface prog_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_wdata;
  logic              cpu_hold;
  logic              load_ok;
  logic              load_err;

  modport master (
    output in_data, in_valid,
    input  in_ready, prog_we, prog_addr, prog_wdata, cpu_hold, load_ok, load_err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, prog_we, prog_addr, prog_wdata, cpu_hold, load_ok, load_err
  );
endinterface

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses SYNC/LEN/{HI,LO}xN/CSUM frames, writes 16-bit words
// from address 0 while holding the CPU, and reports checksum/length/timeout outcome.
module prog_loader #(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 1024
) (
  input  logic         clk,
  input  logic         nReset,
  prog_loader_if.slave bus
);

  localparam int                TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [31:0]       DEPTH    = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_WR   = 3'd4,
    S_CSUM = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t            state_r;
  state_t            state_s;
  logic [8:0]        word_cnt_r;
  logic [7:0]        sum_r;
  logic [7:0]        hi_r;
  logic [TMO_W-1:0]  tmo_r;
  logic              in_ready_r;
  logic              prog_we_r;
  logic [ADDR_W-1:0] prog_addr_r;
  logic [15:0]       prog_wdata_r;
  logic              cpu_hold_r;
  logic              load_ok_r;
  logic              load_err_r;

  logic              xfer_s;
  logic [8:0]        len_words_s;
  logic              len_bad_s;
  logic              tmo_hit_s;
  logic              timing_s;
  logic              csum_good_s;
  logic              ok_s;
  logic              err_s;

  assign xfer_s      = bus.in_valid & in_ready_r;
  assign len_words_s = (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
  assign len_bad_s   = ({23'd0, len_words_s} > DEPTH);
  assign tmo_hit_s   = (tmo_r == TMO_LAST);
  assign timing_s    = (state_r == S_LEN) || (state_r == S_HI) ||
                       (state_r == S_LO)  || (state_r == S_CSUM);
  assign csum_good_s = (csum_add(sum_r, bus.in_data) == 8'd0);

  // Next-state decode and completion pulses
  always_comb begin
    state_s = state_r;
    ok_s    = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (xfer_s && (bus.in_data == SYNC_BYTE)) state_s = S_LEN;
        else                                      state_s = S_IDLE;
      end
      S_LEN: begin
        if (xfer_s)         state_s = len_bad_s ? S_ERR : S_HI;
        else if (tmo_hit_s) state_s = S_ERR;
        else                state_s = S_LEN;
      end
      S_HI: begin
        if (xfer_s)         state_s = S_LO;
        else if (tmo_hit_s) state_s = S_ERR;
        else                state_s = S_HI;
      end
      S_LO: begin
        if (xfer_s)         state_s = S_WR;
        else if (tmo_hit_s) state_s = S_ERR;
        else                state_s = S_LO;
      end
      S_WR: begin
        if (word_cnt_r == 9'd1) state_s = S_CSUM;
        else                    state_s = S_HI;
      end
      S_CSUM: begin
        if (xfer_s) begin
          state_s = S_IDLE;
          if (csum_good_s) ok_s  = 1'b1;
          else             err_s = 1'b1;
        end else if (tmo_hit_s) begin
          state_s = S_ERR;
        end else begin
          state_s = S_CSUM;
        end
      end
      S_ERR:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register and registered control outputs, all derived from the next state
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_r    <= S_IDLE;
      in_ready_r <= 1'b0;
      prog_we_r  <= 1'b0;
      cpu_hold_r <= 1'b0;
      load_ok_r  <= 1'b0;
      load_err_r <= 1'b0;
      tmo_r      <= '0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s != S_WR) && (state_s != S_ERR);
      prog_we_r  <= (state_s == S_WR);
      cpu_hold_r <= (state_s != S_IDLE) && (state_s != S_ERR);
      load_ok_r  <= ok_s;
      load_err_r <= err_s || (state_s == S_ERR);
      tmo_r      <= (timing_s && !xfer_s) ? tmo_r + 1'b1 : '0;
    end
  end

  // Frame datapath: word counter, running checksum, write address and data
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      word_cnt_r   <= 9'd0;
      sum_r        <= 8'd0;
      hi_r         <= 8'd0;
      prog_addr_r  <= '0;
      prog_wdata_r <= 16'd0;
    end else begin
      case (state_r)
        S_LEN: begin
          if (xfer_s) begin
            word_cnt_r  <= len_words_s;
            prog_addr_r <= '0;
            sum_r       <= 8'd0;
          end
        end
        S_HI: begin
          if (xfer_s) begin
            hi_r  <= bus.in_data;
            sum_r <= csum_add(sum_r, bus.in_data);
          end
        end
        S_LO: begin
          if (xfer_s) begin
            sum_r        <= csum_add(sum_r, bus.in_data);
            prog_wdata_r <= {hi_r, bus.in_data};
          end
        end
        // Address wraps naturally only after the last word of a full-depth frame
        S_WR: begin
          prog_addr_r <= prog_addr_r + 1'b1;
          word_cnt_r  <= word_cnt_r - 9'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.prog_we    = prog_we_r;
  assign bus.prog_addr  = prog_addr_r;
  assign bus.prog_wdata = prog_wdata_r;
  assign bus.cpu_hold   = cpu_hold_r;
  assign bus.load_ok    = load_ok_r;
  assign bus.load_err   = load_err_r;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a full-size (ADDR_W=8) and a small (ADDR_W=4) loader
// share one byte source; sel picks which one the stimulus talks to.
module tb_prog_loader;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       nReset;
  logic       sel;
  logic [7:0] bdata;
  logic       bvalid;

  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(8)) ia ();
  prog_loader_if #(.ADDR_W(4)) ib ();

  assign ia.in_data  = bdata;
  assign ia.in_valid = bvalid & ~sel;
  assign ib.in_data  = bdata;
  assign ib.in_valid = bvalid & sel;

  prog_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut8 (
    .clk(clk), .nReset(nReset), .bus(ia));
  prog_loader #(.ADDR_W(4), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut4 (
    .clk(clk), .nReset(nReset), .bus(ib));

  logic        cur_ready, cur_we, cur_hold, cur_ok, cur_err;
  logic [7:0]  cur_addr;
  logic [15:0] cur_wdata;
  assign cur_ready = sel ? ib.in_ready   : ia.in_ready;
  assign cur_we    = sel ? ib.prog_we    : ia.prog_we;
  assign cur_addr  = sel ? {4'd0, ib.prog_addr} : ia.prog_addr;
  assign cur_wdata = sel ? ib.prog_wdata : ia.prog_wdata;
  assign cur_hold  = sel ? ib.cpu_hold   : ia.cpu_hold;
  assign cur_ok    = sel ? ib.load_ok    : ia.load_ok;
  assign cur_err   = sel ? ib.load_err   : ia.load_err;

  // Observer: logs every write and counts cycles each status signal is seen high/low
  int          we_cnt = 0, ok_cnt = 0, err_cnt = 0, hold_cnt = 0, rlow_cnt = 0;
  logic [7:0]  log_addr [512];
  logic [15:0] log_data [512];
  always @(negedge clk) begin
    if (cur_we && we_cnt < 512) begin
      log_addr[we_cnt] <= cur_addr;
      log_data[we_cnt] <= cur_wdata;
    end
    if (cur_we)     we_cnt   <= we_cnt + 1;
    if (cur_ok)     ok_cnt   <= ok_cnt + 1;
    if (cur_err)    err_cnt  <= err_cnt + 1;
    if (cur_hold)   hold_cnt <= hold_cnt + 1;
    if (!cur_ready) rlow_cnt <= rlow_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one byte from a negedge; returns at the negedge after it was accepted
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    bdata  = b;
    bvalid = 1'b1;
    while (!cur_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cur_ready) chk("ready_wait", 32'd0, 32'd1);
    @(negedge clk);
    bvalid = 1'b0;
  endtask

  typedef struct {
    logic        sel;
    logic [79:0] bytes;
    int          n;
    int          exp_we;
    int          exp_ok;
    int          exp_err;
    logic [15:0] exp_w0;
  } vec_t;

  vec_t vt [7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b_we, b_ok, b_err, b_hold, b_rlow, bad, gap;
    logic [7:0] sum, hi, lo;

    vt[0] = '{1'b0, 80'hA5021234_5678EC00_0000,  7, 2, 1, 0, 16'h1234};
    vt[1] = '{1'b0, 80'hA5021234_5678EB00_0000,  7, 2, 0, 1, 16'h1234};
    vt[2] = '{1'b0, 80'h00FF12A5_02123456_78EC, 10, 2, 1, 0, 16'h1234};
    vt[3] = '{1'b1, 80'hA5110000_00000000_0000,  2, 0, 0, 1, 16'h0000};
    vt[4] = '{1'b1, 80'hA5000000_00000000_0000,  2, 0, 0, 1, 16'h0000};
    vt[5] = '{1'b0, 80'hA501A5A5_B6000000_0000,  5, 1, 1, 0, 16'hA5A5};
    vt[6] = '{1'b0, 80'hA5010000_00000000_0000,  5, 1, 1, 0, 16'h0000};

    sel = 1'b0; bdata = 8'd0; bvalid = 1'b0; nReset = 1'b0;
    #12;
    chk("rst_ready", cur_ready, 1'b0);
    chk("rst_we",    cur_we,    1'b0);
    chk("rst_addr",  cur_addr,  8'd0);
    chk("rst_wdata", cur_wdata, 16'd0);
    chk("rst_hold",  cur_hold,  1'b0);
    chk("rst_ok",    cur_ok,    1'b0);
    chk("rst_err",   cur_err,   1'b0);
    @(negedge clk);
    nReset = 1'b1;
    idle(2);
    chk("ready8_after_rst", ia.in_ready, 1'b1);
    chk("ready4_after_rst", ib.in_ready, 1'b1);

    // Back-to-back two-word frame with cycle-exact checks
    b_we = we_cnt; b_ok = ok_cnt; b_err = err_cnt; b_hold = hold_cnt; b_rlow = rlow_cnt;
    send_byte(8'hA5);
    chk("hold_after_sync", cur_hold, 1'b1);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("we_latency", cur_we, 1'b1);
    chk("w0_addr", cur_addr, 8'd0);
    chk("w0_data", cur_wdata, 16'h1234);
    chk("ready_low_in_wr", cur_ready, 1'b0);
    send_byte(8'h56);
    send_byte(8'h78);
    chk("w1_we", cur_we, 1'b1);
    chk("w1_addr", cur_addr, 8'd1);
    chk("w1_data", cur_wdata, 16'h5678);
    send_byte(8'hEC);
    chk("ok_pulse_now", cur_ok, 1'b1);
    chk("hold_falls_with_ok", cur_hold, 1'b0);
    idle(3);
    chk("t1_ok_cycles", ok_cnt - b_ok, 1);
    chk("t1_err_cycles", err_cnt - b_err, 0);
    chk("t1_writes", we_cnt - b_we, 2);
    chk("t1_hold_cycles", hold_cnt - b_hold, 8);
    chk("t1_ready_low_cycles", rlow_cnt - b_rlow, 2);

    // Table of whole frames
    for (int v = 0; v < 7; v++) begin
      sel = vt[v].sel;
      idle(1);
      b_we = we_cnt; b_ok = ok_cnt; b_err = err_cnt;
      for (int k = 0; k < vt[v].n; k++) send_byte(vt[v].bytes[79-8*k -: 8]);
      idle(3);
      chk($sformatf("vec%0d_writes", v), we_cnt - b_we, vt[v].exp_we);
      chk($sformatf("vec%0d_ok", v), ok_cnt - b_ok, vt[v].exp_ok);
      chk($sformatf("vec%0d_err", v), err_cnt - b_err, vt[v].exp_err);
      chk($sformatf("vec%0d_hold", v), cur_hold, 1'b0);
      if (vt[v].exp_we > 0) begin
        chk($sformatf("vec%0d_w0_addr", v), log_addr[b_we], 8'd0);
        chk($sformatf("vec%0d_w0_data", v), log_data[b_we], vt[v].exp_w0);
      end
    end

    // Full-depth frame on the 4-bit loader: 16 words at 0..15, address wraps after
    sel = 1'b1;
    idle(1);
    b_we = we_cnt; b_ok = ok_cnt; b_err = err_cnt;
    sum = 8'd0;
    send_byte(8'hA5);
    send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      hi = 8'(i * 3);
      lo = 8'hF0 ^ 8'(i);
      sum = sum + hi + lo;
      send_byte(hi);
      send_byte(lo);
    end
    send_byte(8'h00 - sum);
    idle(3);
    chk("d16_writes", we_cnt - b_we, 16);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (log_addr[b_we+i] != 8'(i) || log_data[b_we+i] != {8'(i * 3), 8'hF0 ^ 8'(i)}) bad++;
    chk("d16_seq_bad", bad, 0);
    chk("d16_ok", ok_cnt - b_ok, 1);
    chk("d16_err", err_cnt - b_err, 0);
    chk("d16_addr_wrap", cur_addr, 8'd0);

    // Timeout after the HI byte of the second word
    sel = 1'b0;
    idle(1);
    b_we = we_cnt; b_ok = ok_cnt; b_err = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    gap = 0;
    while (!cur_err && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    chk("tmo_cycles", gap, TMO);
    chk("tmo_hold", cur_hold, 1'b0);
    idle(3);
    chk("tmo_writes_kept", we_cnt - b_we, 1);
    chk("tmo_err", err_cnt - b_err, 1);
    chk("tmo_ok", ok_cnt - b_ok, 0);

    // 256-word frame with random source gaps
    idle(1);
    b_we = we_cnt; b_ok = ok_cnt; b_err = err_cnt;
    sum = 8'd0;
    send_byte(8'hA5);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      hi = 8'(i);
      lo = ~8'(i);
      sum = sum + hi + lo;
      idle($urandom_range(0, 5));
      send_byte(hi);
      idle($urandom_range(0, 5));
      send_byte(lo);
    end
    send_byte(8'h00 - sum);
    idle(3);
    chk("f256_writes", we_cnt - b_we, 256);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (log_addr[b_we+i] != 8'(i) || log_data[b_we+i] != {8'(i), ~8'(i)}) bad++;
    chk("f256_seq_bad", bad, 0);
    chk("f256_ok", ok_cnt - b_ok, 1);
    chk("f256_err", err_cnt - b_err, 0);
    chk("f256_addr_wrap", cur_addr, 8'd0);

    // Asynchronous reset in the middle of a frame
    b_err = err_cnt; b_ok = ok_cnt;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("pre_rst_we", cur_we, 1'b1);
    #2;
    nReset = 1'b0;
    #1;
    chk("mid_rst_ready", cur_ready, 1'b0);
    chk("mid_rst_we",    cur_we,    1'b0);
    chk("mid_rst_addr",  cur_addr,  8'd0);
    chk("mid_rst_wdata", cur_wdata, 16'd0);
    chk("mid_rst_hold",  cur_hold,  1'b0);
    chk("mid_rst_ok",    cur_ok,    1'b0);
    chk("mid_rst_err",   cur_err,   1'b0);
    @(negedge clk);
    nReset = 1'b1;
    idle(3);
    chk("mid_rst_no_err_pulse", err_cnt - b_err, 0);
    chk("mid_rst_no_ok_pulse", ok_cnt - b_ok, 0);
    chk("mid_rst_ready_back", cur_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
